// File: rtl/cluster_size_finder.sv
// cluster_size_finder: two-stage pipelined cluster seed and size finder for GEM S-bit frames.
// Runs of set pads are split into chunks of at most MAX_SIZE pads from their low end.
module cluster_size_finder #(
  parameter int N_SBITS = 64,
  parameter int MAX_SIZE = 8,
  parameter int MAX_CLUSTERS = 8,
  parameter int CW = $clog2(MAX_SIZE),
  parameter int NW = $clog2(N_SBITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [N_SBITS-1:0]    sbits_in,
  input  logic                  valid_in,
  output logic [N_SBITS-1:0]    seeds_out,
  output logic [N_SBITS*CW-1:0] sizes_out,
  output logic [NW-1:0]         n_clusters_out,
  output logic                  overflow_out,
  output logic                  valid_out
);
  localparam int W = 2 * MAX_SIZE;
  localparam int LW = $clog2(W + 1);

  logic [N_SBITS-1:0]    start_d, start_q, seeds_d;
  logic [LW-1:0]         len_d [N_SBITS];
  logic [LW-1:0]         len_q [N_SBITS];
  logic                  valid_q;
  logic [N_SBITS+W-1:0]  padded;
  logic [N_SBITS*CW-1:0] sizes_d;
  logic [NW-1:0]         count_d;

  // Length of the run of ones starting at bit 0 of the window, saturating at the window width.
  function automatic logic [LW-1:0] ones_run(input logic [W-1:0] w);
    logic [LW-1:0] n;
    logic go;
    n = '0;
    go = 1'b1;
    for (int k = 0; k < W; k++) begin
      go = go & w[k];
      n = n + LW'(go);
    end
    return n;
  endfunction

  assign padded = {{W{1'b0}}, sbits_in};
  assign start_d = sbits_in & ~{sbits_in[N_SBITS-2:0], 1'b0};

  for (genvar i = 0; i < N_SBITS; i++) begin : g_len
    assign len_d[i] = ones_run(padded[i +: W]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < N_SBITS; i++) len_q[i] <= '0;
    end else if (en) begin
      start_q <= start_d;
      valid_q <= valid_in;
      for (int i = 0; i < N_SBITS; i++) len_q[i] <= len_d[i];
    end
  end

  // A pad MAX_SIZE above a seed is another seed while the run is still longer than one chunk.
  always_comb begin
    logic [LW-1:0] m;
    m = '0;
    seeds_d = start_q;
    sizes_d = '0;
    count_d = '0;
    for (int i = MAX_SIZE; i < N_SBITS; i++)
      seeds_d[i] = seeds_d[i] | (seeds_d[i-MAX_SIZE] & (len_q[i-MAX_SIZE] > LW'(MAX_SIZE)));
    seeds_d = valid_q ? seeds_d : '0;
    for (int i = 0; i < N_SBITS; i++) begin
      m = len_q[i] > LW'(MAX_SIZE) ? LW'(MAX_SIZE) : len_q[i];
      sizes_d[i*CW +: CW] = seeds_d[i] ? CW'(m - 1'b1) : '0;
      count_d = count_d + NW'(seeds_d[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seeds_out <= '0;
      sizes_out <= '0;
      n_clusters_out <= '0;
      overflow_out <= 1'b0;
      valid_out <= 1'b0;
    end else if (en) begin
      seeds_out <= seeds_d;
      sizes_out <= sizes_d;
      n_clusters_out <= count_d;
      overflow_out <= count_d > NW'(MAX_CLUSTERS);
      valid_out <= valid_q;
    end
  end
endmodule
